// File: rtl/blink_sched.sv
// ---------------------------------------------------------------------------
// blink_sched
//
// Command-driven scheduler for a phase-accumulator LED blinker. A command
// {increment, blink count} is accepted over a valid/ready handshake while
// idle. The block then runs a 32-bit phase accumulator at that increment.
// The LED follows the accumulator MSB. Accumulator wraps are counted as
// blink periods. After the last period the LED is held dark for GAP_CYCLES
// cycles, and then completion is signalled with a one-cycle o_done pulse.
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_reset_n      synchronous, active-low reset
//   i_cmd_valid    command present
//   o_cmd_ready    command can be accepted (high only while idle)
//   i_cmd_inc      phase increment per clock
//   i_cmd_count    number of blink periods; 0 = run until abort
//   i_abort        terminate the current command (ignored while idle)
//   o_led          LED drive
//   o_busy         a command is in progress (RUN or GAP)
//   o_done         one-cycle pulse when a command completes normally
//   o_remaining    blink periods still to run (0 when idle or free-running)
//   o_default_inc  constant increment that gives a 1 Hz blink
// ---------------------------------------------------------------------------
module blink_sched #(
    parameter int          CLOCK_RATE_HZ = 100_000_000,
    parameter logic [31:0] DEFAULT_INC   = 32'((1 << 30) / (CLOCK_RATE_HZ / 4)),
    parameter int          GAP_CYCLES    = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [31:0] i_cmd_inc,
    input  logic [7:0]  i_cmd_count,
    input  logic        i_abort,
    output logic        o_led,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_remaining,
    output logic [31:0] o_default_inc
);

    // The gap counter only ever holds GAP_CYCLES-1 down to 0.
    localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_acc;
    logic [31:0]   r_inc;
    logic [7:0]    r_remaining;
    logic [GW-1:0] r_gap;
    logic          r_done;

    state_t        w_state_next;
    logic [31:0]   w_acc_next;
    logic [31:0]   w_inc_next;
    logic [7:0]    w_remaining_next;
    logic [GW-1:0] w_gap_next;
    logic          w_done_next;
    logic [32:0]   w_sum;
    logic          w_carry;

    // The carry out of the 33-bit add marks the end of one blink period.
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry = w_sum[32];

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_inc_next       = r_inc;
        w_remaining_next = r_remaining;
        w_gap_next       = r_gap;
        w_done_next      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Abort has no meaning here, so a command that arrives with
                // abort in the same cycle is still taken.
                if (i_cmd_valid) begin
                    w_inc_next       = i_cmd_inc;
                    w_remaining_next = i_cmd_count;
                    w_acc_next       = 32'd0;
                    w_state_next     = ST_RUN;
                end
            end

            ST_RUN: begin
                if (i_abort) begin
                    w_acc_next       = 32'd0;
                    w_remaining_next = 8'd0;
                    w_state_next     = ST_IDLE;
                end else begin
                    w_acc_next = w_sum[31:0];
                    if (w_carry) begin
                        if (r_remaining == 8'd1) begin
                            w_acc_next       = 32'd0;
                            w_remaining_next = 8'd0;
                            w_gap_next       = GAP_LOAD;
                            w_state_next     = ST_GAP;
                        end else if (r_remaining > 8'd1) begin
                            w_remaining_next = r_remaining - 8'd1;
                        end
                        // A count of 0 selects free-run mode, so wraps are
                        // not counted.
                    end
                end
            end

            ST_GAP: begin
                if (i_abort) begin
                    w_acc_next       = 32'd0;
                    w_remaining_next = 8'd0;
                    w_state_next     = ST_IDLE;
                end else if (r_gap == '0) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_gap_next = r_gap - GW'(1);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= 32'd0;
            r_inc       <= 32'd0;
            r_remaining <= 8'd0;
            r_gap       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_inc       <= w_inc_next;
            r_remaining <= w_remaining_next;
            r_gap       <= w_gap_next;
            r_done      <= w_done_next;
        end
    end

    assign o_cmd_ready   = (r_state == ST_IDLE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_led         = (r_state == ST_RUN) && r_acc[31];
    assign o_done        = r_done;
    assign o_remaining   = r_remaining;
    assign o_default_inc = DEFAULT_INC;

endmodule

// File: tb/tb_blink_sched.sv
// ---------------------------------------------------------------------------
// tb_blink_sched
//
// Directed testbench for blink_sched with GAP_CYCLES=4 and
// CLOCK_RATE_HZ=300_000. Inputs are driven and outputs are sampled on the
// falling clock edge. Each task runs one scenario and checks its own results.
// ---------------------------------------------------------------------------
module tb_blink_sched;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_inc;
    logic [7:0]  cmd_count;
    logic        abort;
    logic        led;
    logic        busy;
    logic        done;
    logic [7:0]  remaining;
    logic [31:0] default_inc;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    blink_sched #(
        .CLOCK_RATE_HZ (300_000),
        .GAP_CYCLES    (GAP)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_inc     (cmd_inc),
        .i_cmd_count   (cmd_count),
        .i_abort       (abort),
        .o_led         (led),
        .o_busy        (busy),
        .o_done        (done),
        .o_remaining   (remaining),
        .o_default_inc (default_inc)
    );

    task automatic test_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_inc   = 32'h4000_0000;
        cmd_count = 8'd1;
        abort     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready cyc%0d got %b want 1", i, cmd_ready); else n_pass++;
            n_total++; if (busy !== 1'b0) $display("FAIL reset_busy cyc%0d got %b want 0", i, busy); else n_pass++;
            n_total++; if (led !== 1'b0) $display("FAIL reset_led cyc%0d got %b want 0", i, led); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL reset_done cyc%0d got %b want 0", i, done); else n_pass++;
            n_total++; if (remaining !== 8'd0) $display("FAIL reset_rem cyc%0d got %0d want 0", i, remaining); else n_pass++;
        end
        cmd_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_release_busy got %b want 0", busy); else n_pass++;
        $display("test_reset: done");
    endtask

    task automatic test_default_inc();
        n_total++; if (default_inc !== 32'd14316) $display("FAIL default_inc got %0d want 14316", default_inc); else n_pass++;
        $display("test_default_inc: o_default_inc=%0d", default_inc);
    endtask

    // inc = 1/4 turn, so each period is 4 RUN cycles with the LED low for 2
    // cycles and then high for 2 cycles.
    task automatic test_two_blinks();
        logic [7:0] pat;
        logic       exp_led;
        pat = 8'b1100_1100;
        cmd_valid = 1'b1; cmd_inc = 32'h4000_0000; cmd_count = 8'd2;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL blink_ready_pre got %b want 1", cmd_ready); else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            exp_led = (k <= 8) ? pat[k-1] : 1'b0;
            n_total++; if (led !== exp_led) $display("FAIL blink_led cyc%0d got %b want %b", k, led, exp_led); else n_pass++;
            n_total++; if (busy !== 1'b1) $display("FAIL blink_busy cyc%0d got %b want 1", k, busy); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL blink_done_early cyc%0d got %b want 0", k, done); else n_pass++;
            if (k <= 8) begin
                n_total++; if (remaining !== ((k <= 4) ? 8'd2 : 8'd1)) $display("FAIL blink_rem cyc%0d got %0d want %0d", k, remaining, (k <= 4) ? 2 : 1); else n_pass++;
            end
            @(negedge clk);
        end
        n_total++; if (done !== 1'b1) $display("FAIL blink_done cyc13 got %b want 1", done); else n_pass++;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL blink_ready_post got %b want 1", cmd_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL blink_busy_post got %b want 0", busy); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL blink_done_width got %b want 0", done); else n_pass++;
        $display("test_two_blinks: inc=40000000 count=2 complete");
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        logic       exp_led;
        pat = 8'b1100_1100;
        cmd_valid = 1'b1; cmd_inc = 32'h4000_0000; cmd_count = 8'd2;
        @(negedge clk);
        // The second command waits with valid held high.
        cmd_inc = 32'h8000_0000; cmd_count = 8'd1;
        for (int k = 1; k <= 12; k++) begin
            exp_led = (k <= 8) ? pat[k-1] : 1'b0;
            n_total++; if (led !== exp_led) $display("FAIL b2b_led1 cyc%0d got %b want %b", k, led, exp_led); else n_pass++;
            n_total++; if (cmd_ready !== 1'b0) $display("FAIL b2b_ready cyc%0d got %b want 0", k, cmd_ready); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (done !== 1'b1) $display("FAIL b2b_done1 cyc13 got %b want 1", done); else n_pass++;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready13 got %b want 1", cmd_ready); else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 14; k <= 19; k++) begin
            exp_led = (k == 15);
            n_total++; if (led !== exp_led) $display("FAIL b2b_led2 cyc%0d got %b want %b", k, led, exp_led); else n_pass++;
            n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy2 cyc%0d got %b want 1", k, busy); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL b2b_done_early cyc%0d got %b want 0", k, done); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (done !== 1'b1) $display("FAIL b2b_done2 cyc20 got %b want 1", done); else n_pass++;
        @(negedge clk);
        $display("test_back_to_back: two commands complete");
    endtask

    task automatic test_abort_free_run();
        cmd_valid = 1'b1; cmd_inc = 32'h4000_0000; cmd_count = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            n_total++; if (remaining !== 8'd0) $display("FAIL free_rem cyc%0d got %0d want 0", k, remaining); else n_pass++;
            n_total++; if (busy !== 1'b1) $display("FAIL free_busy cyc%0d got %b want 1", k, busy); else n_pass++;
            n_total++; if (led !== ((k % 4) == 3 || (k % 4) == 0)) $display("FAIL free_led cyc%0d got %b", k, led); else n_pass++;
            if (k == 10) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL free_abort_busy got %b want 0", busy); else n_pass++;
        n_total++; if (led !== 1'b0) $display("FAIL free_abort_led got %b want 0", led); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL free_abort_done got %b want 0", done); else n_pass++;
        n_total++; if (remaining !== 8'd0) $display("FAIL free_abort_rem got %0d want 0", remaining); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL free_abort_done2 got %b want 0", done); else n_pass++;
        $display("test_abort_free_run: aborted after 10 cycles");
    endtask

    task automatic test_abort_final_carry();
        cmd_valid = 1'b1; cmd_inc = 32'h4000_0000; cmd_count = 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;                  // RUN cycle 4 carries out
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < GAP + 2; k++) begin
            n_total++; if (busy !== 1'b0) $display("FAIL carry_abort_busy cyc%0d got %b want 0", k, busy); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL carry_abort_done cyc%0d got %b want 0", k, done); else n_pass++;
            @(negedge clk);
        end
        $display("test_abort_final_carry: abort took priority");
    endtask

    task automatic test_accept_with_abort();
        cmd_valid = 1'b1; abort = 1'b1; cmd_inc = 32'h4000_0000; cmd_count = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL idle_abort_accept got %b want 1", busy); else n_pass++;
        n_total++; if (remaining !== 8'd3) $display("FAIL idle_abort_rem got %0d want 3", remaining); else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL idle_abort_exit got %b want 0", busy); else n_pass++;
        $display("test_accept_with_abort: command taken then aborted");
    endtask

    // 0x6000_0000 does not divide 2^32: ceil(2^32/inc) = 3 RUN cycles.
    task automatic test_non_divisor();
        cmd_valid = 1'b1; cmd_inc = 32'h6000_0000; cmd_count = 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            n_total++; if (led !== (k == 3)) $display("FAIL nondiv_led cyc%0d got %b want %b", k, led, (k == 3)); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL nondiv_done_early cyc%0d got %b want 0", k, done); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (done !== 1'b1) $display("FAIL nondiv_done cyc8 got %b want 1", done); else n_pass++;
        @(negedge clk);
        $display("test_non_divisor: inc=60000000 count=1 complete");
    endtask

    task automatic test_reset_mid_cmd();
        cmd_valid = 1'b1; cmd_inc = 32'h4000_0000; cmd_count = 8'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_total++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (remaining !== 8'd0) $display("FAIL midreset_rem got %0d want 0", remaining); else n_pass++;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_quiet cyc%0d done=%b busy=%b want 0,0", k, done, busy); else n_pass++;
        end
        $display("test_reset_mid_cmd: command dropped");
    endtask

    initial begin
        test_reset();
        test_default_inc();
        test_two_blinks();
        test_back_to_back();
        test_abort_free_run();
        test_abort_final_carry();
        test_accept_with_abort();
        test_non_divisor();
        test_reset_mid_cmd();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
